io_supply_seq: RTL



---
 rtl/io_supply_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/io_supply_seq.sv
// io_supply_seq: core-side sequencer for the IO-ring supplies.
// Debounces the synchronized VDDIO power-good, then releases pad isolation
// and enables output drivers in order; reverses the order on power-down and
// forces pads safe in one cycle on supply loss.
// Optional build macro: IO_SUPPLY_SEQ_FAULT_LATCH_EN
//   defined   -> supply loss parks in FAULT with fault_o held until en_i=0
//   undefined -> supply loss returns to WAIT_PG, fault_o is a 1-cycle pulse
module io_supply_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_CYCLES     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic pg_async_i,
  output logic iso_en_o,
  output logic drv_en_o,
  output logic ready_o,
  output logic fault_o
);

  localparam int MAXC = (DEBOUNCE_CYCLES > STEP_CYCLES) ? DEBOUNCE_CYCLES : STEP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WAIT_PG = 3'd1,
    ST_UNISO   = 3'd2,
    ST_DRV     = 3'd3,
    ST_ON      = 3'd4,
    ST_PD_DRV  = 3'd5,
`ifdef IO_SUPPLY_SEQ_FAULT_LATCH_EN
    ST_PD_ISO  = 3'd6,
    ST_FAULT   = 3'd7
`else
    ST_PD_ISO  = 3'd6
`endif
  } state_t;

`ifdef IO_SUPPLY_SEQ_FAULT_LATCH_EN
  localparam state_t LOSS_TGT = ST_FAULT;
`else
  localparam state_t LOSS_TGT = ST_WAIT_PG;
`endif

  logic          r_pg_meta, r_pg_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_loss;

  // Two-flop synchronizer for the asynchronous power-good
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pg_meta <= 1'b0;
      r_pg_s    <= 1'b0;
    end else begin
      r_pg_meta <= pg_async_i;
      r_pg_s    <= r_pg_meta;
    end
  end

  // Next-state and dwell counter; supply loss overrides everything else
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_loss      = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (en_i) w_state_nxt = ST_WAIT_PG;
      end
      ST_WAIT_PG: begin
        if (!en_i)                   w_state_nxt = ST_OFF;
        else if (r_pg_s) begin
          if (r_cnt == DEB_LAST)     w_state_nxt = ST_UNISO;
          else                       w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_UNISO: begin
        if (!r_pg_s)                 w_loss      = 1'b1;
        else if (!en_i)              w_state_nxt = ST_PD_DRV;
        else if (r_cnt == STEP_LAST) w_state_nxt = ST_DRV;
        else                         w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_DRV: begin
        if (!r_pg_s)                 w_loss      = 1'b1;
        else if (!en_i)              w_state_nxt = ST_PD_DRV;
        else if (r_cnt == STEP_LAST) w_state_nxt = ST_ON;
        else                         w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_ON: begin
        if (!r_pg_s)                 w_loss      = 1'b1;
        else if (!en_i)              w_state_nxt = ST_PD_DRV;
      end
      // Power-down runs to completion; en_i is only looked at again in OFF
      ST_PD_DRV: begin
        if (!r_pg_s)                 w_loss      = 1'b1;
        else if (r_cnt == STEP_LAST) w_state_nxt = ST_PD_ISO;
        else                         w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_PD_ISO: begin
        if (!r_pg_s)                 w_loss      = 1'b1;
        else if (r_cnt == STEP_LAST) w_state_nxt = ST_OFF;
        else                         w_cnt_nxt   = r_cnt + 1'b1;
      end
`ifdef IO_SUPPLY_SEQ_FAULT_LATCH_EN
      ST_FAULT: begin
        if (!en_i) w_state_nxt = ST_OFF;
      end
`endif
      default: w_state_nxt = ST_OFF;
    endcase
    if (w_loss) begin
      w_state_nxt = LOSS_TGT;
      w_cnt_nxt   = '0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered pad controls, decoded so they always track the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      iso_en_o <= 1'b1;
      drv_en_o <= 1'b0;
      ready_o  <= 1'b0;
      fault_o  <= 1'b0;
    end else begin
      iso_en_o <= (w_state_nxt == ST_OFF) || (w_state_nxt == ST_WAIT_PG) ||
                  (w_state_nxt == ST_PD_ISO) || (w_state_nxt == LOSS_TGT);
      drv_en_o <= (w_state_nxt == ST_DRV) || (w_state_nxt == ST_ON);
      ready_o  <= (w_state_nxt == ST_ON);
`ifdef IO_SUPPLY_SEQ_FAULT_LATCH_EN
      fault_o  <= (w_state_nxt == ST_FAULT);
`else
      fault_o  <= w_loss;
`endif
    end
  end

endmodule
